// File: rtl/lsu_agu_seq_pkg.sv
// Shared types for the LSU address-generation / operand-sequencing stage.
// Misalignment trapping is selected by the LSU_AGU_MISALIGN_TRAP_EN macro (see lsu_agu_seq.sv).
package lsu_agu_seq_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } cs_size;

    typedef enum logic {
        EXT_ZERO = 1'b0,
        EXT_SIGN = 1'b1
    } cs_ext;

    typedef enum logic [2:0] {
        AGU_IDLE  = 3'd0,
        AGU_HIGH  = 3'd1,
        AGU_CHECK = 3'd2,
        AGU_ISSUE = 3'd3,
        AGU_WAIT  = 3'd4
    } agu_state_e;

    function automatic logic is_misaligned(cs_size size, logic [1:0] addr_lo);
        case (size)
            SIZE_H:  return addr_lo[0];
            SIZE_W:  return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    // Clears the low address bits that a naturally aligned access of this size cannot use.
    function automatic logic [1:0] align_lo(cs_size size, logic [1:0] addr_lo);
        case (size)
            SIZE_H:  return {addr_lo[1], 1'b0};
            SIZE_W:  return 2'b00;
            default: return addr_lo;
        endcase
    endfunction

endpackage

// File: rtl/lsu_agu_seq_if.sv
// Request bus from the AGU sequencer to load_store_unit.
// Handshake: lsu_start_o is held with stable dir/size/addr/wdata until lsu_ready_i is seen in the
// same cycle; that cycle is the single transfer. Completion is the first cycle lsu_valid_i or lsu_err_i is high.
interface lsu_agu_seq_if;
    import lsu_agu_seq_pkg::*;

    logic        lsu_start_o;
    logic        lsu_dir_o;
    cs_size      lsu_size_o;
    logic [31:0] lsu_addr_o;
    logic [31:0] lsu_wdata_o;
    logic        lsu_ready_i;
    logic        lsu_valid_i;
    logic        lsu_err_i;

    modport master (
        output lsu_start_o, lsu_dir_o, lsu_size_o, lsu_addr_o, lsu_wdata_o,
        input  lsu_ready_i, lsu_valid_i, lsu_err_i
    );

    modport slave (
        input  lsu_start_o, lsu_dir_o, lsu_size_o, lsu_addr_o, lsu_wdata_o,
        output lsu_ready_i, lsu_valid_i, lsu_err_i
    );

endinterface

// File: rtl/lsu_agu_seq_adder.sv
// 16-bit adder with carry in/out; the sequencer reuses one instance for both address halves.
module agu_half_adder16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {16'b0, cin};

endmodule

// File: rtl/lsu_agu_seq.sv
// Effective-address / store-data sequencer feeding load_store_unit over a 16-bit regfile port.
// Define LSU_AGU_MISALIGN_TRAP_EN to trap misaligned accesses; otherwise low address bits are forced aligned.
module lsu_agu_seq
    import lsu_agu_seq_pkg::*;
#(
    parameter int IMM_W       = 12,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             dir_i,
    input  cs_size           size_i,
    input  logic [IMM_W-1:0] imm_i,
    input  logic [15:0]      rs1_half_i,
    input  logic [15:0]      rs2_half_i,
    output logic             rf_hsel_o,
    output logic             ready_o,
    output logic             done_o,
    output logic             err_o,
    output logic             misalign_o,
    lsu_agu_seq_if.master    lsu,
    output agu_state_e       dbg_state_o
);

    localparam int TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

    agu_state_e      state_q, state_d;
    logic            dir_q;
    cs_size          size_q;
    logic [15:0]     sext_hi_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic            carry_q;
    logic [TW-1:0]   tmo_q;

    logic [31:0]     imm_sext;
    logic [15:0]     add_b;
    logic            add_cin;
    logic [15:0]     add_sum;
    logic            add_cout;
    logic            accept;
    logic            tmo_hit;

    assign imm_sext = {{(32 - IMM_W){imm_i[IMM_W-1]}}, imm_i};
    assign accept   = start_i && (state_q == AGU_IDLE);
    assign tmo_hit  = (TIMEOUT_CYC != 0) && (tmo_q == TW'(TIMEOUT_CYC));

    // Low half is added at accept straight from imm_i; high half uses the latched extension and carry.
    assign add_b   = (state_q == AGU_IDLE) ? imm_sext[15:0] : sext_hi_q;
    assign add_cin = (state_q == AGU_HIGH) && carry_q;

    agu_half_adder16 u_adder (
        .a    (rs1_half_i),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= AGU_IDLE;
            dir_q     <= 1'b0;
            size_q    <= SIZE_B;
            sext_hi_q <= 16'h0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            carry_q   <= 1'b0;
            tmo_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                dir_q          <= dir_i;
                size_q         <= size_i;
                sext_hi_q      <= imm_sext[31:16];
                addr_q[15:0]   <= add_sum;
                carry_q        <= add_cout;
                wdata_q[15:0]  <= rs2_half_i;
            end
            if (state_q == AGU_HIGH) begin
                addr_q[31:16]  <= add_sum;
                wdata_q[31:16] <= rs2_half_i;
            end
            // Zero on WAIT entry, so the count equals the number of WAIT cycles already spent.
            if (state_q == AGU_WAIT) begin
                tmo_q <= tmo_q + TW'(1);
            end else begin
                tmo_q <= '0;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        rf_hsel_o       = 1'b0;
        ready_o         = 1'b0;
        done_o          = 1'b0;
        err_o           = 1'b0;
        misalign_o      = 1'b0;
        lsu.lsu_start_o = 1'b0;
        case (state_q)
            AGU_IDLE: begin
                ready_o = 1'b1;
                if (start_i) state_d = AGU_HIGH;
            end
            AGU_HIGH: begin
                rf_hsel_o = 1'b1;
                state_d   = AGU_CHECK;
            end
            AGU_CHECK: begin
                state_d = AGU_ISSUE;
`ifdef LSU_AGU_MISALIGN_TRAP_EN
                if (is_misaligned(size_q, addr_q[1:0])) begin
                    err_o      = 1'b1;
                    misalign_o = 1'b1;
                    state_d    = AGU_IDLE;
                end
`endif
            end
            AGU_ISSUE: begin
                lsu.lsu_start_o = 1'b1;
                if (lsu.lsu_ready_i) state_d = AGU_WAIT;
            end
            AGU_WAIT: begin
                if (lsu.lsu_err_i) begin
                    err_o   = 1'b1;
                    state_d = AGU_IDLE;
                end else if (lsu.lsu_valid_i) begin
                    done_o  = 1'b1;
                    state_d = AGU_IDLE;
                end else if (tmo_hit) begin
                    err_o   = 1'b1;
                    state_d = AGU_IDLE;
                end
            end
            default: state_d = AGU_IDLE;
        endcase
    end

    assign lsu.lsu_dir_o   = dir_q;
    assign lsu.lsu_size_o  = size_q;
    assign lsu.lsu_wdata_o = wdata_q;
`ifdef LSU_AGU_MISALIGN_TRAP_EN
    assign lsu.lsu_addr_o  = addr_q;
`else
    assign lsu.lsu_addr_o  = {addr_q[31:2], align_lo(size_q, addr_q[1:0])};
`endif
    assign dbg_state_o = state_q;

endmodule
